// File: rtl/stdp_pkg.sv
// Shared types and helpers for the pair-based STDP array updater.
//   state_t    : scan FSM state (IDLE, SCAN)
//   ageDelta   : update magnitude for a spike found at a given age
//   clampSum   : saturate a signed sum into 0..maxVal
package stdp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Magnitude halves with every extra cycle of separation; age 0 never
    // contributes (coincident spikes are not a pairing).
    function automatic int ageDelta(input logic found, input int age, input int aMax);
        if (!found || age < 1) begin
            return 0;
        end
        return aMax >> (age - 1);
    endfunction

    function automatic int clampSum(input int value, input int maxVal);
        if (value < 0) begin
            return 0;
        end
        if (value > maxVal) begin
            return maxVal;
        end
        return value;
    endfunction

endpackage

// File: rtl/spike_age_encoder.sv
// Finds the most recent past spike in a history vector.
//   hist  : history, bit k = spike k cycles ago (bit 0 = current cycle)
//   found : at least one spike at age >= 1
//   age   : lowest set bit index >= 1 (0 when nothing found)
module spike_age_encoder #(
    parameter int HIST_DEPTH = 16,
    parameter int AGE_W      = 4
) (
    input  logic [HIST_DEPTH-1:0] hist,
    output logic                  found,
    output logic [AGE_W-1:0]      age
);

    logic [HIST_DEPTH-1:0] aged;

    // Age 0 is the current cycle and is not a pairing partner.
    assign aged = hist & ~HIST_DEPTH'(1);

    // Walk from oldest to youngest so the youngest hit wins.
    always_comb begin
        found = 1'b0;
        age   = '0;
        for (int k = HIST_DEPTH - 1; k >= 1; k--) begin
            if (aged[k]) begin
                found = 1'b1;
                age   = AGE_W'(k);
            end
        end
    end

endmodule

// File: rtl/stdp_array_updater.sv
// Pair-based STDP engine for N_PRE plastic synapses onto one neuron.
// Every cycle each spike history shifts in its current spike. An enabled
// event (write & any spike) snapshots all histories and scans the channels
// one per cycle, applying saturating potentiation/depression.
//   clock, reset       : rising-edge clock, async active-high reset
//   write              : learning enable, events ignored while low
//   post_spike         : postsynaptic spike this cycle
//   pre_spike          : presynaptic spikes this cycle
//   rd_sel / rd_weight : registered weight read-back (old value on collision)
//   busy               : scan in progress
//   upd_valid/idx/weight : one-cycle strobe per weight that actually changed
//   drop_cnt           : saturating count of events dropped while busy
//   fsmState           : debug view of the scan FSM
// Strobe semantics: upd_valid is a pure one-cycle pulse with no ready;
// upd_idx/upd_weight are meaningful only in the cycle upd_valid is high.
module stdp_array_updater
    import stdp_pkg::*;
#(
    parameter int N_PRE      = 16,
    parameter int HIST_DEPTH = 16,
    parameter int W_WIDTH    = 4,
    parameter int W_INIT     = 8,
    parameter int A_MAX      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write,
    input  logic                     post_spike,
    input  logic [N_PRE-1:0]         pre_spike,
    input  logic [$clog2(N_PRE)-1:0] rd_sel,
    output logic [W_WIDTH-1:0]       rd_weight,
    output logic                     busy,
    output logic                     upd_valid,
    output logic [$clog2(N_PRE)-1:0] upd_idx,
    output logic [W_WIDTH-1:0]       upd_weight,
    output logic [7:0]               drop_cnt,
    output state_t                   fsmState
);

    localparam int IDX_W = $clog2(N_PRE);
    localparam int AGE_W = $clog2(HIST_DEPTH);
    localparam int SUM_W = W_WIDTH + 2;
    localparam int W_MAX = (1 << W_WIDTH) - 1;
    localparam logic [IDX_W-1:0]   LAST_CH = IDX_W'(N_PRE - 1);
    localparam logic [W_WIDTH-1:0] INIT_W  = W_WIDTH'(W_INIT);

    state_t state, stateNext;
    logic [IDX_W-1:0]      chIdx;
    logic [HIST_DEPTH-1:0] preHist  [N_PRE];
    logic [HIST_DEPTH-1:0] preShift [N_PRE];
    logic [HIST_DEPTH-1:0] preSnap  [N_PRE];
    logic [HIST_DEPTH-1:0] postHist, postShift, postSnap;
    logic [W_WIDTH-1:0]    weights  [N_PRE];

    logic spikeEvent, lastCh, accept, dropEvt, changed;
    logic preFound, postFound;
    logic [AGE_W-1:0] preAge, postAge;
    logic signed [SUM_W-1:0] ltp, ltd, sumW;
    logic [W_WIDTH-1:0] curW, newW;

    // Next history value doubles as the snapshot so the current-cycle
    // spikes are part of the event being evaluated.
    always_comb begin
        for (int i = 0; i < N_PRE; i++) begin
            preShift[i] = {preHist[i][HIST_DEPTH-2:0], pre_spike[i]};
        end
    end
    assign postShift = {postHist[HIST_DEPTH-2:0], post_spike};

    // An event in the final scan cycle is accepted: the last channel is
    // evaluated from the old snapshot in the same cycle the new one loads,
    // which lets events be spaced exactly N_PRE cycles apart.
    assign spikeEvent = write & (post_spike | (|pre_spike));
    assign lastCh     = (chIdx == LAST_CH);
    assign accept     = spikeEvent & ((state == IDLE) | lastCh);
    assign dropEvt    = spikeEvent & ~accept;

    assign busy     = (state == SCAN);
    assign fsmState = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = SCAN;
            SCAN:    if (lastCh && !accept) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chIdx <= '0;
        end else if (accept) begin
            chIdx <= '0;
        end else if (state == SCAN) begin
            chIdx <= lastCh ? '0 : chIdx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PRE; i++) begin
                preHist[i] <= '0;
                preSnap[i] <= '0;
            end
            postHist <= '0;
            postSnap <= '0;
        end else begin
            for (int i = 0; i < N_PRE; i++) begin
                preHist[i] <= preShift[i];
                if (accept) preSnap[i] <= preShift[i];
            end
            postHist <= postShift;
            if (accept) postSnap <= postShift;
        end
    end

    spike_age_encoder #(.HIST_DEPTH(HIST_DEPTH), .AGE_W(AGE_W)) preEnc (
        .hist  (preSnap[chIdx]),
        .found (preFound),
        .age   (preAge)
    );

    spike_age_encoder #(.HIST_DEPTH(HIST_DEPTH), .AGE_W(AGE_W)) postEnc (
        .hist  (postSnap),
        .found (postFound),
        .age   (postAge)
    );

    // LTP needs post now and an earlier pre; LTD needs pre now and an
    // earlier post. Both may apply; the net is applied in one step.
    always_comb begin
        ltp = '0;
        ltd = '0;
        if (postSnap[0]) ltp = SUM_W'(ageDelta(preFound, int'(preAge), A_MAX));
        if (preSnap[chIdx][0]) ltd = SUM_W'(ageDelta(postFound, int'(postAge), A_MAX));
        curW = weights[chIdx];
        sumW = $signed({2'b00, curW}) + ltp - ltd;
        newW = W_WIDTH'(clampSum(int'(sumW), W_MAX));
    end

    assign changed = (state == SCAN) && (newW != curW);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PRE; i++) begin
                weights[i] <= INIT_W;
            end
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_weight <= '0;
        end else begin
            upd_valid <= changed;
            if (changed) begin
                weights[chIdx] <= newW;
                upd_idx        <= chIdx;
                upd_weight     <= newW;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_weight <= INIT_W;
        end else begin
            rd_weight <= weights[rd_sel];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (dropEvt && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_stdp_array_updater.sv
module tb_stdp_array_updater;
    import stdp_pkg::*;

    localparam int N_PRE      = 16;
    localparam int HIST_DEPTH = 16;
    localparam int W_WIDTH    = 4;
    localparam int W_INIT     = 8;
    localparam int A_MAX      = 4;
    localparam int IDX_W      = 4;
    localparam int RING       = 32;
    localparam int W_TOP      = 15;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic write = 1'b0;
    logic post_spike = 1'b0;
    logic [N_PRE-1:0] pre_spike = '0;
    logic [IDX_W-1:0] rd_sel = '0;
    logic [W_WIDTH-1:0] rd_weight;
    logic busy;
    logic upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic [W_WIDTH-1:0] upd_weight;
    logic [7:0] drop_cnt;
    state_t fsmState;

    always #5 clock = ~clock;

    stdp_array_updater #(
        .N_PRE(N_PRE), .HIST_DEPTH(HIST_DEPTH), .W_WIDTH(W_WIDTH),
        .W_INIT(W_INIT), .A_MAX(A_MAX)
    ) dut (
        .clock(clock), .reset(reset), .write(write), .post_spike(post_spike),
        .pre_spike(pre_spike), .rd_sel(rd_sel), .rd_weight(rd_weight),
        .busy(busy), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_weight(upd_weight), .drop_cnt(drop_cnt), .fsmState(fsmState)
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Spike log by absolute cycle number; an event at cycle t pairs with the
    // most recent partner spike 1..HIST_DEPTH-1 cycles earlier.
    typedef struct {
        int cyc;
        int idx;
        int w;
    } updRec_t;

    updRec_t exp_q[$];
    int modelW [N_PRE];
    int cyc     = 100;
    int scanEnd = 0;
    int expDrop = 0;
    logic [N_PRE-1:0] preRing [RING];
    logic postRing [RING];

    function automatic void modelReset();
        for (int i = 0; i < N_PRE; i++) modelW[i] = W_INIT;
        for (int r = 0; r < RING; r++) begin
            preRing[r]  = '0;
            postRing[r] = 1'b0;
        end
        exp_q.delete();
        expDrop = 0;
        scanEnd = 0;
    endfunction

    function automatic int preAgeAt(input int ch, input int t);
        for (int a = 1; a < HIST_DEPTH; a++) begin
            if (preRing[(t - a) % RING][ch]) return a;
        end
        return 0;
    endfunction

    function automatic int postAgeAt(input int t);
        for (int a = 1; a < HIST_DEPTH; a++) begin
            if (postRing[(t - a) % RING]) return a;
        end
        return 0;
    endfunction

    function automatic void modelScan(input int t);
        int pa, pb, ltp, ltd, nw;
        pb = postAgeAt(t);
        for (int i = 0; i < N_PRE; i++) begin
            pa  = preAgeAt(i, t);
            ltp = (postRing[t % RING] && pa > 0) ? (A_MAX >> (pa - 1)) : 0;
            ltd = (preRing[t % RING][i] && pb > 0) ? (A_MAX >> (pb - 1)) : 0;
            nw  = modelW[i] + ltp - ltd;
            if (nw < 0) nw = 0;
            if (nw > W_TOP) nw = W_TOP;
            if (nw != modelW[i]) begin
                exp_q.push_back('{cyc: t + 2 + i, idx: i, w: nw});
                modelW[i] = nw;
            end
        end
    endfunction

    // ---------------- scoreboard / compare ----------------
    initial begin : compare_proc
        int outCyc;
        logic expBusy;
        modelReset();
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                modelReset();
            end else begin
                preRing[cyc % RING]  = pre_spike;
                postRing[cyc % RING] = post_spike;
                if (write && (post_spike || (|pre_spike))) begin
                    if (cyc >= scanEnd) begin
                        scanEnd = cyc + N_PRE;
                        modelScan(cyc);
                    end else if (expDrop < 255) begin
                        expDrop++;
                    end
                end
            end
            @(negedge clock);
            if (reset) begin
                modelReset();
                check("rst_busy", int'(busy), 0);
                check("rst_upd_valid", int'(upd_valid), 0);
                check("rst_upd_idx", int'(upd_idx), 0);
                check("rst_upd_weight", int'(upd_weight), 0);
                check("rst_drop_cnt", int'(drop_cnt), 0);
                check("rst_rd_weight", int'(rd_weight), W_INIT);
            end else begin
                outCyc  = cyc + 1;
                expBusy = (outCyc <= scanEnd);
                check("busy", int'(busy), int'(expBusy));
                check("fsm_state", int'(fsmState), expBusy ? int'(SCAN) : int'(IDLE));
                check("drop_cnt", int'(drop_cnt), expDrop);
                while (exp_q.size() > 0 && exp_q[0].cyc < outCyc) begin
                    check("upd_missed_cycle", outCyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == outCyc) begin
                    check("upd_valid", int'(upd_valid), 1);
                    check("upd_idx", int'(upd_idx), exp_q[0].idx);
                    check("upd_weight", int'(upd_weight), exp_q[0].w);
                    void'(exp_q.pop_front());
                end else begin
                    check("upd_valid_idle", int'(upd_valid), 0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic w, input logic p, input logic [N_PRE-1:0] pr);
        write      = w;
        post_spike = p;
        pre_spike  = pr;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0);
    endtask

    task automatic readCheck(input int ch, input int exp, input string name);
        rd_sel = IDX_W'(ch);
        step(1'b0, 1'b0, '0);
        check(name, int'(rd_weight), exp);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim_proc
        idle(3);
        reset = 1'b0;

        // Reset state: every weight reads back as the initial value.
        for (int ch = 0; ch < N_PRE; ch++) readCheck(ch, 8, "reset_weight");
        check("reset_drop", int'(drop_cnt), 0);

        // pre[3] one cycle before post: +4 on channel 3 only.
        step(1'b0, 1'b0, 16'h0008);
        step(1'b1, 1'b1, '0);
        idle(20);
        readCheck(3, 12, "ltp_ch3");
        readCheck(2, 8, "ltp_ch2_untouched");

        // post two cycles before pre[5]: -2 on channel 5.
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 16'h0020);
        idle(20);
        readCheck(5, 6, "ltd_ch5");

        // Repeated LTP on channel 0: 8 -> 12 -> 15 and then stuck.
        step(1'b0, 1'b0, 16'h0001);
        step(1'b1, 1'b1, '0);
        idle(18);
        readCheck(0, 12, "ltp_ch0_first");
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b0, 16'h0001);
            step(1'b1, 1'b1, '0);
            idle(18);
        end
        readCheck(0, 15, "ltp_ch0_sat");

        // Mirrored LTD on channel 1: 8 -> 4 -> 0 and then stuck.
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 16'h0002);
        idle(18);
        readCheck(1, 4, "ltd_ch1_first");
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b1, '0);
            step(1'b1, 1'b0, 16'h0002);
            idle(18);
        end
        readCheck(1, 0, "ltd_ch1_sat");

        // Drop while busy, write-low spike ignored, event in final scan cycle accepted.
        step(1'b1, 1'b1, '0);        // T: accepted
        idle(2);
        step(1'b1, 1'b1, '0);        // T+3: dropped
        step(1'b0, 1'b1, '0);        // T+4: write low, not counted
        idle(10);
        step(1'b0, 1'b0, 16'h0004);  // T+15: pre[2], no event
        step(1'b1, 1'b1, '0);        // T+16: accepted, pairs with pre[2]
        idle(20);
        check("drop_once", int'(drop_cnt), 1);
        readCheck(2, 12, "boundary_event_ch2");

        // Reset during scan cycle 7, after channel 4 was already written.
        rd_sel = IDX_W'(4);
        step(1'b0, 1'b0, 16'h0010);
        step(1'b1, 1'b1, '0);
        idle(7);
        check("midscan_ch4_written", int'(rd_weight), 12);
        reset = 1'b1;
        #1;
        check("midscan_reset_busy", int'(busy), 0);
        step(1'b0, 1'b0, '0);
        check("after_reset_busy", int'(busy), 0);
        reset = 1'b0;
        for (int ch = 0; ch < N_PRE; ch++) readCheck(ch, 8, "after_reset_weight");
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/stdp_array_updater.md
# stdp_array_updater

Parametrised pair-based STDP engine for an array of N_PRE plastic synapses onto one postsynaptic neuron. Keeps a spike-history shift register per presynaptic line and for the postsynaptic line, holds all synaptic weights, and on each enabled spike event walks every channel once, applying saturating potentiation/depression. It replaces the single-channel, mux-selected updater; a learning-enable plus a read-back port serve the neuron core and debug logic.

## Interface
Parameters:
- N_PRE, 16, number of presynaptic channels (≥2)
- HIST_DEPTH, 16, history length in cycles (age 0 = current cycle)
- W_WIDTH, 4, unsigned weight width
- W_INIT, 8, weight value after reset
- A_MAX, 4, peak update magnitude at age 1

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- write  in  1  learning enable; events ignored while low
- post_spike  in  1  postsynaptic spike, this cycle
- pre_spike  in  N_PRE  presynaptic spikes, this cycle
- rd_sel  in  $clog2(N_PRE)  read-back channel
- rd_weight  out  W_WIDTH  weight of rd_sel, registered
- busy  out  1  scan in progress
- upd_valid  out  1  one-cycle strobe: a weight changed
- upd_idx  out  $clog2(N_PRE)  channel of the changed weight
- upd_weight  out  W_WIDTH  new weight value
- drop_cnt  out  8  saturating count of events dropped while busy

## Operation
- Every cycle, regardless of write/busy: each history shifts in its spike at bit 0; bit HIST_DEPTH-1 discarded.
- Event = write & (post_spike | |pre_spike). Event in IDLE: snapshot all histories (including the current-cycle bits), go to SCAN.
- FSM: IDLE → SCAN (channel counter 0..N_PRE-1, one channel per cycle) → IDLE after channel N_PRE-1. No other states.
- Per channel i, from snapshot: age = index of lowest set bit ≥1 (age 0 excluded).
  - LTP: post bit0 = 1 and pre_i has a spike at age a → ltp = A_MAX >> (a-1), else 0.
  - LTD: pre_i bit0 = 1 and post has a spike at age b → ltd = A_MAX >> (b-1), else 0.
  - Both apply → net = ltp − ltd in one step.
  - new = clamp(w + net, 0, 2^W_WIDTH−1); compute in W_WIDTH+2 signed bits.
- Weight written and upd_valid pulsed only when new ≠ w.
- Event while busy: no trigger, drop_cnt += 1 (sticks at 255); histories still shift.
- Event in the cycle busy drops to 0 is accepted normally.
- write low: no trigger, no drop count.

## Timing
- Event sampled at edge T; busy = 1 for cycles T+1 … T+N_PRE; channel i evaluated in cycle T+1+i.
- upd_valid/upd_idx/upd_weight registered: visible in cycle T+2+i for one cycle.
- Back-to-back scans: minimum event spacing N_PRE cycles.
- rd_weight: 1-cycle latency; same-cycle read of a channel being written returns the old value.
- Reset (any time, including mid-scan): all weights = W_INIT, histories = 0, FSM IDLE, busy = 0, upd_valid = 0, upd_idx = 0, upd_weight = 0, rd_weight = W_INIT, drop_cnt = 0. Aborted scan leaves no partial writes.

## Structure
- Package stdp_pkg: FSM state enum (IDLE, SCAN), function for delta from age (A_MAX >> (age−1), 0 if no spike), saturating clamp function.
- Sub-module spike_age_encoder: HIST_DEPTH-bit vector → found flag + lowest-set age ≥1; instantiated once for the selected pre channel and once for post.
- Weights stored in an N_PRE × W_WIDTH register array (no RAM macro).

## Test plan
- Reset then read all channels → rd_weight = 8 each; busy, upd_valid, drop_cnt = 0.
- pre_spike[3] at cycle 0, post_spike at cycle 1, write = 1 → single upd_valid, upd_idx = 3, upd_weight = 12; others unchanged.
- post_spike at cycle 0, pre_spike[5] at cycle 2 → upd_idx = 5, upd_weight = 8 − 2 = 6.
- Ten LTP pairings on channel 0 → weight saturates at 15, later pairings give no upd_valid; mirrored LTD saturates at 0.
- Event, then a second event 3 cycles later (N_PRE = 16) → drop_cnt = 1, only one scan; event at the busy-falling cycle is accepted.
- Assert reset in scan cycle 7 after weights changed → all weights back to 8, busy = 0 next cycle.
